// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg : shared types and constants for the mem_slice stage             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  localparam int MEM_RD = 1;
  localparam int MEM_WR = 0;
  localparam int WBW    = 7;

endpackage
`default_nettype wire

// File: rtl/mem_slice_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_slice_if : data-memory req/gnt/rvalid handshake bundle               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface mem_slice_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_write_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_write_buffer : single-entry posted store buffer with hit lookup      |
// | Used only when MEM_WRITE_BUFFER_EN is defined.  Rev 1.0                  |
// +--------------------------------------------------------------------------+
module mem_write_buffer #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_enq,
  input  logic [AW-1:0] i_enq_addr,
  input  logic [DW-1:0] i_enq_data,
  input  logic          i_drain,
  input  logic [AW-1:0] i_lookup_addr,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_hit
);
  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  // Enqueue wins over drain: a full-buffer store enqueues on the drain's grant edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_enq) begin
      r_valid <= 1'b1;
      r_addr  <= i_enq_addr;
      r_data  <= i_enq_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_hit   = r_valid && (r_addr == i_lookup_addr);
endmodule
`default_nettype wire

// File: rtl/mem_slice.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_slice : EX/MEM register + data-memory access + MEM/WB register       |
// | Optional posted store buffer: MEM_WRITE_BUFFER_EN.  Rev 1.0              |
// +--------------------------------------------------------------------------+
module mem_slice #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int WBW = mem_pkg::WBW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_in,
  input  logic [WBW-1:0] WB_in,
  input  logic [1:0]     M_in,
  input  logic [AW-1:0]  addr_in,
  input  logic [DW-1:0]  data_in,
  input  logic [DW-1:0]  result_in,
  input  logic [2:0]     flags_in,
  mem_slice_if.master    dmem,
  output logic           stall_out,
  output logic [2:0]     flags_prv,
  output logic [WBW-1:0] WB_out,
  output logic [DW-1:0]  mem_rdata,
  output logic [DW-1:0]  result_out
);
  import mem_pkg::*;

  logic [WBW-1:0] r_wb;
  logic [1:0]     r_m;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_data;
  logic [DW-1:0]  r_result;
  logic [2:0]     r_flags;
  logic [WBW-1:0] r_wb_out;
  logic [DW-1:0]  r_rdata;
  logic [DW-1:0]  r_result_out;

  mem_state_e r_state, w_state_nxt;

  logic          w_mem_op, w_store, w_load;
  logic          w_issue, w_issue_store;
  logic          w_done, w_stall;
  logic          w_req, w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata_cap;

  assign w_mem_op = |r_m;
  assign w_store  = r_m[MEM_WR];
  assign w_load   = r_m[MEM_RD] & ~r_m[MEM_WR];

`ifdef MEM_WRITE_BUFFER_EN
  logic          w_buf_valid, w_buf_hit, w_drain_req, w_drain_gnt, w_enq;
  logic [AW-1:0] w_buf_addr;
  logic [DW-1:0] w_buf_data;

  mem_write_buffer #(.AW(AW), .DW(DW)) u_wbuf (
    .clk           (clk),
    .rst           (rst),
    .i_enq         (w_enq),
    .i_enq_addr    (r_addr),
    .i_enq_data    (r_data),
    .i_drain       (w_drain_gnt),
    .i_lookup_addr (r_addr),
    .o_valid       (w_buf_valid),
    .o_addr        (w_buf_addr),
    .o_data        (w_buf_data),
    .o_hit         (w_buf_hit)
  );

  // Loads go to memory only once the buffer is empty, which keeps program order.
  assign w_issue       = w_load & ~w_buf_hit & ~w_buf_valid;
  assign w_issue_store = 1'b0;
  assign w_drain_req   = w_buf_valid & (r_state == IDLE) & ~(w_load & w_buf_hit);
  assign w_drain_gnt   = w_drain_req & dmem.gnt;
  assign w_enq         = w_store & w_done;
`else
  assign w_issue       = w_mem_op;
  assign w_issue_store = w_store;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_issue) w_state_nxt = dmem.gnt ? (w_issue_store ? IDLE : WAIT) : REQ;
      REQ:  if (dmem.gnt) w_state_nxt = w_issue_store ? IDLE : WAIT;
      WAIT: if (dmem.rvalid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_req       = w_issue & (r_state != WAIT);
    w_we        = w_issue_store;
    w_addr      = r_addr;
    w_wdata     = r_data;
    w_rdata_cap = dmem.rdata;
`ifdef MEM_WRITE_BUFFER_EN
    if (w_drain_req) begin
      w_req   = 1'b1;
      w_we    = 1'b1;
      w_addr  = w_buf_addr;
      w_wdata = w_buf_data;
    end
    if (w_load & w_buf_hit) w_rdata_cap = w_buf_data;
    w_done = ~w_mem_op
           | ((r_state == WAIT) & dmem.rvalid)
           | (w_store & (~w_buf_valid | w_drain_gnt))
           | (w_load & w_buf_hit);
`else
    w_done = ~w_mem_op
           | ((r_state == WAIT) & dmem.rvalid)
           | (w_store & (r_state != WAIT) & dmem.gnt);
`endif
    w_stall = w_mem_op & ~w_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb     <= '0;
      r_m      <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else if (!w_stall) begin
      r_wb     <= flush_in ? '0 : WB_in;
      r_m      <= flush_in ? 2'b00 : M_in;
      r_addr   <= addr_in;
      r_data   <= data_in;
      r_result <= result_in;
      r_flags  <= flags_in;
    end
  end

  // A stalled cycle emits a bubble; result and load data simply hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_out     <= '0;
      r_rdata      <= '0;
      r_result_out <= '0;
    end else if (w_done) begin
      r_wb_out     <= r_wb;
      r_result_out <= r_result;
      if (w_load) r_rdata <= w_rdata_cap;
    end else begin
      r_wb_out <= '0;
    end
  end

  assign dmem.req   = w_req;
  assign dmem.we    = w_we;
  assign dmem.addr  = w_addr;
  assign dmem.wdata = w_wdata;
  assign stall_out  = w_stall;
  assign flags_prv  = r_flags;
  assign WB_out     = r_wb_out;
  assign mem_rdata  = r_rdata;
  assign result_out = r_result_out;
endmodule
`default_nettype wire

// File: tb/tb_mem_slice.sv
`default_nettype none
// tb_mem_slice : table vectors, directed multi-cycle sequences and a randomized
// transaction-level model for mem_slice.
module tb_mem_slice;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush_in;
  logic [6:0]  WB_in;
  logic [1:0]  M_in;
  logic [15:0] addr_in, data_in, result_in;
  logic [2:0]  flags_in;
  logic        stall_out;
  logic [2:0]  flags_prv;
  logic [6:0]  WB_out;
  logic [15:0] mem_rdata, result_out;

  always #5 clk = ~clk;

  mem_slice_if #(.AW(16), .DW(16)) dmem ();

  mem_slice #(.AW(16), .DW(16), .WBW(7)) dut (
    .clk(clk), .rst(rst), .flush_in(flush_in), .WB_in(WB_in), .M_in(M_in),
    .addr_in(addr_in), .data_in(data_in), .result_in(result_in), .flags_in(flags_in),
    .dmem(dmem), .stall_out(stall_out), .flags_prv(flags_prv), .WB_out(WB_out),
    .mem_rdata(mem_rdata), .result_out(result_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] wb, input logic [1:0] m, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] r, input logic [2:0] f,
                       input logic fl);
    WB_in = wb; M_in = m; addr_in = a; data_in = d; result_in = r; flags_in = f; flush_in = fl;
  endtask

  task automatic idle_in();
    drive(7'h0, 2'b00, 16'h0, 16'h0, 16'h0, 3'b000, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = 16'h0;
    rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  typedef struct {
    logic [6:0]  wb;
    logic [1:0]  m;
    logic        fl;
    logic [15:0] res;
    logic [2:0]  fg;
    logic [6:0]  e_wb;
    logic [15:0] e_res;
    logic [2:0]  e_fg;
  } vec_t;

  vec_t vecs[6];

  // Reference model state for the randomized run
  logic [6:0]  md_wb;
  logic [1:0]  md_m;
  logic [15:0] md_addr, md_data, md_res;
  bit          md_gr;
  logic [6:0]  e_wb;
  logic [15:0] e_res, e_rd;
  logic [2:0]  e_fl;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit op, st, ld, req_e, done_e, stall_e;

    rst = 1'b1;
    idle_in();
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = 16'h0;
    @(negedge clk);
    check("rst_wb_out", WB_out, 0);
    check("rst_result", result_out, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_flags", flags_prv, 0);
    check("rst_stall", stall_out, 0);
    check("rst_req", dmem.req, 0);
    rst = 1'b0;

    // ---- table vectors: pass-through and flushed captures ----
    vecs[0] = '{7'h41, 2'b00, 1'b0, 16'h1234, 3'b101, 7'h41, 16'h1234, 3'b101};
    vecs[1] = '{7'h7F, 2'b00, 1'b0, 16'hFFFF, 3'b111, 7'h7F, 16'hFFFF, 3'b111};
    vecs[2] = '{7'h55, 2'b10, 1'b1, 16'hAAAA, 3'b010, 7'h00, 16'hAAAA, 3'b010};
    vecs[3] = '{7'h2A, 2'b01, 1'b1, 16'h0042, 3'b001, 7'h00, 16'h0042, 3'b001};
    vecs[4] = '{7'h13, 2'b11, 1'b1, 16'h0BAD, 3'b100, 7'h00, 16'h0BAD, 3'b100};
    vecs[5] = '{7'h00, 2'b00, 1'b0, 16'h0000, 3'b000, 7'h00, 16'h0000, 3'b000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vecs[i].wb, vecs[i].m, 16'h0100, 16'h0200, vecs[i].res, vecs[i].fg, vecs[i].fl);
      @(negedge clk);
      idle_in();
      #1;
      check("vec_req", dmem.req, 0);
      check("vec_stall", stall_out, 0);
      check("vec_flags", flags_prv, vecs[i].e_fg);
      @(negedge clk);
      check("vec_wb_out", WB_out, vecs[i].e_wb);
      check("vec_result", result_out, vecs[i].e_res);
    end

`ifndef MEM_WRITE_BUFFER_EN
    // ---- zero-wait store ----
    do_reset();
    @(negedge clk);
    drive(7'h2C, 2'b01, 16'h0010, 16'hBEEF, 16'h0001, 3'b000, 1'b0);
    #1 check("st_stall0", stall_out, 0);
    @(negedge clk);
    idle_in();
    dmem.gnt = 1'b1;
    #1;
    check("st_req", dmem.req, 1);
    check("st_we", dmem.we, 1);
    check("st_addr", dmem.addr, 16'h0010);
    check("st_wdata", dmem.wdata, 16'hBEEF);
    check("st_stall1", stall_out, 0);
    @(negedge clk);
    dmem.gnt = 1'b0;
    #1;
    check("st_req_off", dmem.req, 0);
    check("st_stall2", stall_out, 0);
    check("st_wb_out", WB_out, 7'h2C);

    // ---- load: grant after two cycles, rvalid three cycles after grant ----
    do_reset();
    @(negedge clk);
    drive(7'h22, 2'b10, 16'h0020, 16'h0000, 16'h0777, 3'b000, 1'b0);
    @(negedge clk);
    drive(7'h33, 2'b00, 16'h0000, 16'h0000, 16'h0999, 3'b000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      dmem.gnt = (c == 2);
      #1;
      check("ld_req", dmem.req, 1);
      check("ld_addr", dmem.addr, 16'h0020);
      check("ld_we", dmem.we, 0);
      check("ld_stall_req", stall_out, 1);
      if (c > 0) check("ld_bubble", WB_out, 0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dmem.gnt = 1'b0;
      dmem.rvalid = (c == 2);
      dmem.rdata = (c == 2) ? 16'hCAFE : 16'h1111;
      #1;
      check("ld_req_wait", dmem.req, 0);
      check("ld_stall_wait", stall_out, (c == 2) ? 1'b0 : 1'b1);
      check("ld_bubble_wait", WB_out, 0);
    end
    @(negedge clk);
    dmem.rvalid = 1'b0;
    idle_in();
    check("ld_wb_out", WB_out, 7'h22);
    check("ld_rdata", mem_rdata, 16'hCAFE);
    check("ld_result", result_out, 16'h0777);
    @(negedge clk);
    check("ld_next_wb", WB_out, 7'h33);
    check("ld_next_res", result_out, 16'h0999);
`else
    // ---- posted store followed by a load hitting the buffer ----
    do_reset();
    @(negedge clk);
    drive(7'h11, 2'b01, 16'h0030, 16'h5555, 16'h0000, 3'b000, 1'b0);
    @(negedge clk);
    drive(7'h12, 2'b10, 16'h0030, 16'h0000, 16'h0000, 3'b000, 1'b0);
    #1;
    check("wb_st_stall", stall_out, 0);
    check("wb_st_req", dmem.req, 0);
    @(negedge clk);
    idle_in();
    #1;
    check("wb_ld_stall", stall_out, 0);
    check("wb_ld_req", dmem.req, 0);
    @(negedge clk);
    check("wb_ld_rdata", mem_rdata, 16'h5555);
    check("wb_ld_wb_out", WB_out, 7'h12);
`endif

    // ---- reset while a request is pending ----
    do_reset();
    @(negedge clk);
    drive(7'h44, 2'b10, 16'h0050, 16'h0000, 16'h0000, 3'b000, 1'b0);
    @(negedge clk);
    idle_in();
    #1 check("rq_req_before", dmem.req, 1);
    rst = 1'b1;
    #1 check("rq_req_after", dmem.req, 0);
    check("rq_stall_after", stall_out, 0);
    rst = 1'b0;

    // ---- reset while waiting for rvalid ----
    do_reset();
    @(negedge clk);
    drive(7'h5A, 2'b00, 16'h0000, 16'h0000, 16'h1111, 3'b011, 1'b0);
    @(negedge clk);
    drive(7'h6B, 2'b10, 16'h0040, 16'h0000, 16'h2222, 3'b110, 1'b0);
    @(negedge clk);
    idle_in();
    dmem.gnt = 1'b1;
    #1 check("rw_req", dmem.req, 1);
    @(negedge clk);
    dmem.gnt = 1'b0;
    #1;
    check("rw_stall_wait", stall_out, 1);
    check("rw_result_pre", result_out, 16'h1111);
    rst = 1'b1;
    #1;
    check("rw_req_rst", dmem.req, 0);
    check("rw_stall_rst", stall_out, 0);
    check("rw_wb_rst", WB_out, 0);
    check("rw_result_rst", result_out, 0);
    check("rw_flags_rst", flags_prv, 0);
    @(negedge clk);
    rst = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata = 16'hDEAD;
    #1 check("rw_late_stall", stall_out, 0);
    @(negedge clk);
    dmem.rvalid = 1'b0;
    check("rw_late_rdata", mem_rdata, 0);
    check("rw_late_wb", WB_out, 0);

`ifndef MEM_WRITE_BUFFER_EN
    // ---- randomized run against a transaction-level model ----
    do_reset();
    md_wb = '0; md_m = '0; md_addr = '0; md_data = '0; md_res = '0; md_gr = 0;
    e_wb = '0; e_res = '0; e_rd = '0; e_fl = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      check("rnd_wb_out", WB_out, e_wb);
      check("rnd_result", result_out, e_res);
      check("rnd_rdata", mem_rdata, e_rd);
      check("rnd_flags", flags_prv, e_fl);
      drive(7'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            3'($urandom), ($urandom_range(0, 7) == 0));
      dmem.gnt    = ($urandom_range(0, 2) != 0);
      dmem.rvalid = ($urandom_range(0, 1) == 1);
      dmem.rdata  = 16'($urandom);
      #1;
      op = (md_m != 2'b00);
      st = md_m[0];
      ld = (md_m == 2'b10);
      req_e  = op && !md_gr;
      done_e = !op ? 1'b1 : (st ? dmem.gnt : (md_gr && dmem.rvalid));
      stall_e = op && !done_e;
      check("rnd_stall", stall_out, stall_e);
      check("rnd_req", dmem.req, req_e);
      if (req_e) begin
        check("rnd_we", dmem.we, st);
        check("rnd_addr", dmem.addr, md_addr);
        if (st) check("rnd_wdata", dmem.wdata, md_data);
      end
      if (done_e) begin
        e_wb = md_wb;
        e_res = md_res;
        if (ld) e_rd = dmem.rdata;
      end else begin
        e_wb = '0;
      end
      if (ld && !md_gr && dmem.gnt) md_gr = 1;
      if (!stall_e) begin
        md_wb = flush_in ? 7'h0 : WB_in;
        md_m = flush_in ? 2'b00 : M_in;
        md_addr = addr_in;
        md_data = data_in;
        md_res = result_in;
        md_gr = 0;
        e_fl = flags_in;
      end
    end
    @(negedge clk);
    check("rnd_final_wb", WB_out, e_wb);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
